// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types: the input-buffer entry layout and its default depth.
package fpu_ss_pkg;

    localparam int unsigned IN_BUF_DEPTH_DEFAULT = 4;

    // 32 + 2*32 + 16 + 8 + 5 + 3 = 128 bits
    typedef struct packed {
        logic [31:0]      instr;
        logic [1:0][31:0] rs;
        logic [15:0]      id;
        logic [7:0]       core_id;
        logic [4:0]       rd;
        logic             is_load;
        logic             is_store;
        logic             use_fpu;
    } in_buf_entry_t;

endpackage

// File: rtl/fpu_ss_in_buf_if.sv
// Valid/ready/data channel used for both the push and the pop side of the input buffer.
// A transfer happens on a rising clock edge where valid & ready; data is meaningful only while valid.
interface fpu_ss_in_buf_if #(
    parameter int unsigned DATA_WIDTH = 128
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fpu_ss_in_buf_ptr.sv
// Wrapping pointer for the input buffer; wraps explicitly so DEPTH need not be a power of two.
module fpu_ss_in_buf_ptr #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fpu_ss_in_buf.sv
// FPU subsystem input instruction buffer: FIFO between issue predecoder and controller.
// Optional same-cycle bypass when empty: define FPU_SS_IN_BUF_FALL_THROUGH_EN.
module fpu_ss_in_buf
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH      = IN_BUF_DEPTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = $bits(in_buf_entry_t),
    localparam int unsigned UW        = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    fpu_ss_in_buf_if.slave          push,
    fpu_ss_in_buf_if.master         pop,
    output logic [UW-1:0]           usage_o,
    output logic                    full_o,
    output logic                    empty_o
);

    if (DEPTH == 0) begin : g_pass
        // No storage: the issue stage talks straight to the controller.
        assign push.ready = pop.ready & ~flush_i;
        assign pop.valid  = push.valid & ~flush_i;
        assign pop.data   = push.data;
        assign usage_o    = '0;
        assign full_o     = 1'b1;
        assign empty_o    = 1'b1;
    end else begin : g_buf
        localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         rd_ptr;
        logic [PW-1:0]         wr_ptr;
        logic [UW-1:0]         usage_q;
        logic                  bypass_valid;
        logic                  bypass;
        logic                  wr_en;
        logic                  rd_en;

        assign full_o  = (usage_q == UW'(DEPTH));
        assign empty_o = (usage_q == '0);
        assign usage_o = usage_q;

`ifdef FPU_SS_IN_BUF_FALL_THROUGH_EN
        assign bypass_valid = empty_o & push.valid & ~flush_i;
`else
        assign bypass_valid = 1'b0;
`endif

        // Ready never looks at the pop side, so a full buffer refuses even while draining.
        assign push.ready = ~full_o & ~flush_i;
        assign pop.valid  = (~empty_o | bypass_valid) & ~flush_i;
        assign bypass     = bypass_valid & pop.ready;
        assign wr_en      = push.valid & push.ready & ~bypass;
        assign rd_en      = pop.valid & pop.ready & ~bypass;

        always_comb begin
            pop.data = '0;
            if (bypass_valid) begin
                pop.data = push.data;
            end else if (!empty_o) begin
                pop.data = mem[rd_ptr];
            end
        end

        fpu_ss_in_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (rd_en),
            .clr    (flush_i),
            .ptr    (rd_ptr)
        );

        fpu_ss_in_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (wr_en),
            .clr    (flush_i),
            .ptr    (wr_ptr)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                usage_q <= '0;
            end else if (flush_i) begin
                usage_q <= '0;
            end else begin
                usage_q <= usage_q + UW'(wr_en) - UW'(rd_en);
            end
        end

        // Entries are not reset; pop.data is masked to zero while empty instead.
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem[wr_ptr] <= push.data;
            end
        end

`ifndef SYNTHESIS
        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(push.valid && push.ready && full_o))
                    else $error("in_buf: push accepted while full");
                assert (!(rd_en && empty_o))
                    else $error("in_buf: pop from empty storage");
                assert (usage_q <= UW'(DEPTH))
                    else $error("in_buf: usage exceeds depth");
            end
        end
`endif
    end

endmodule

// File: tb/tb_fpu_ss_in_buf.sv
// Directed bench for fpu_ss_in_buf: DEPTH=4, DEPTH=3 (wrap) and DEPTH=0 (pass-through) instances.
module tb_fpu_ss_in_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_flush = 1'b0;
    logic b_flush = 1'b0;
    logic c_flush = 1'b0;
    logic [2:0] a_usage;
    logic [1:0] b_usage;
    logic [0:0] c_usage;
    logic a_full, a_empty, b_full, b_empty, c_full, c_empty;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) a_push ();
    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) a_pop ();
    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) b_push ();
    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) b_pop ();
    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) c_push ();
    fpu_ss_in_buf_if #(.DATA_WIDTH(32)) c_pop ();

    fpu_ss_in_buf #(.DEPTH(4), .DATA_WIDTH(32)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .push(a_push), .pop(a_pop),
        .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty)
    );
    fpu_ss_in_buf #(.DEPTH(3), .DATA_WIDTH(32)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .push(b_push), .pop(b_pop),
        .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty)
    );
    fpu_ss_in_buf #(.DEPTH(0), .DATA_WIDTH(32)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .push(c_push), .pop(c_pop),
        .usage_o(c_usage), .full_o(c_full), .empty_o(c_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic pv, input logic [31:0] pd, input logic pr);
        a_push.valid = pv;
        a_push.data  = pd;
        a_pop.ready  = pr;
    endtask

    initial begin
        a_drive(1'b0, 32'h0, 1'b0);
        b_push.valid = 1'b0; b_push.data = '0; b_pop.ready = 1'b0;
        c_push.valid = 1'b0; c_push.data = '0; c_pop.ready = 1'b0;

        // Reset state
        #1;
        check("rst_usage", 32'(a_usage), 0);
        check("rst_push_ready", 32'(a_push.ready), 1);
        check("rst_pop_valid", 32'(a_pop.valid), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_pop_data", a_pop.data, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Fill/drain
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 32'hA1 + 32'(i), 1'b0);
            tick();
        end
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("fill_full", 32'(a_full), 1);
        check("fill_push_ready", 32'(a_push.ready), 0);
        check("fill_usage", 32'(a_usage), 4);
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b0, 32'h0, 1'b1);
            #1;
            check("drain_valid", 32'(a_pop.valid), 1);
            check("drain_data", a_pop.data, 32'hA1 + 32'(i));
            tick();
        end
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("drain_empty", 32'(a_empty), 1);
        check("drain_pop_valid", 32'(a_pop.valid), 0);

        // Simultaneous push and pop at full
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 32'hB0 + 32'(i), 1'b0);
            tick();
        end
        a_drive(1'b1, 32'hEE, 1'b1);
        #1;
        check("full_pp_push_ready", 32'(a_push.ready), 0);
        check("full_pp_pop_valid", 32'(a_pop.valid), 1);
        tick();
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("full_pp_usage", 32'(a_usage), 3);
        for (int i = 1; i < 4; i++) begin
            a_drive(1'b0, 32'h0, 1'b1);
            #1;
            check("full_pp_data", a_pop.data, 32'hB0 + 32'(i));
            tick();
        end
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("full_pp_empty", 32'(a_empty), 1);

        // Flush
        a_drive(1'b1, 32'hC0, 1'b0); tick();
        a_drive(1'b1, 32'hC1, 1'b0); tick();
        a_drive(1'b1, 32'hCC, 1'b1);
        a_flush = 1'b1;
        #1;
        check("flush_push_ready", 32'(a_push.ready), 0);
        check("flush_pop_valid", 32'(a_pop.valid), 0);
        tick();
        a_flush = 1'b0;
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("flush_usage", 32'(a_usage), 0);
        check("flush_empty", 32'(a_empty), 1);
        a_drive(1'b1, 32'hD0, 1'b0); tick();
        a_drive(1'b0, 32'h0, 1'b1);
        #1;
        check("post_flush_data", a_pop.data, 32'hD0);
        tick();
        a_drive(1'b0, 32'h0, 1'b0);

        // Fall-through / minimum latency
        a_drive(1'b1, 32'h55, 1'b1);
        #1;
`ifdef FPU_SS_IN_BUF_FALL_THROUGH_EN
        check("ft_pop_valid", 32'(a_pop.valid), 1);
        check("ft_pop_data", a_pop.data, 32'h55);
`else
        check("lat_pop_valid", 32'(a_pop.valid), 0);
`endif
        tick();
        a_push.valid = 1'b0;
        #1;
`ifdef FPU_SS_IN_BUF_FALL_THROUGH_EN
        check("ft_usage", 32'(a_usage), 0);
        check("ft_pop_valid_after", 32'(a_pop.valid), 0);
`else
        check("lat_pop_valid_after", 32'(a_pop.valid), 1);
        check("lat_pop_data", a_pop.data, 32'h55);
        check("lat_usage", 32'(a_usage), 1);
`endif
        tick();
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("lat_empty", 32'(a_empty), 1);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, 32'hE0 + 32'(i), 1'b0);
            tick();
        end
        a_drive(1'b0, 32'h0, 1'b0);
        #1;
        check("mid_usage_pre", 32'(a_usage), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_usage", 32'(a_usage), 0);
        check("mid_rst_pop_valid", 32'(a_pop.valid), 0);
        check("mid_rst_push_ready", 32'(a_push.ready), 1);
        tick();
        rst_n = 1'b1;
        a_drive(1'b1, 32'hF0, 1'b0); tick();
        a_drive(1'b0, 32'h0, 1'b1);
        #1;
        check("mid_rst_first_pop", a_pop.data, 32'hF0);
        tick();
        a_drive(1'b0, 32'h0, 1'b0);

        // Wrap on DEPTH=3 at usage 2
        for (int i = 0; i < 2; i++) begin
            b_push.valid = 1'b1; b_push.data = 32'(i); b_pop.ready = 1'b0;
            exp_q.push_back(32'(i));
            tick();
        end
        #1;
        check("wrap_usage", 32'(b_usage), 2);
        for (int i = 2; i < 10; i++) begin
            b_push.valid = 1'b1; b_push.data = 32'(i); b_pop.ready = 1'b1;
            #1;
            check("wrap_push_ready", 32'(b_push.ready), 1);
            check("wrap_data", b_pop.data, exp_q.pop_front());
            exp_q.push_back(32'(i));
            tick();
        end
        b_push.valid = 1'b0;
        while (exp_q.size() > 0) begin
            b_pop.ready = 1'b1;
            #1;
            check("wrap_tail", b_pop.data, exp_q.pop_front());
            tick();
        end
        b_pop.ready = 1'b0;
        #1;
        check("wrap_empty", 32'(b_empty), 1);

        // DEPTH=0 pass-through
        c_push.valid = 1'b1; c_push.data = 32'h77; c_pop.ready = 1'b0;
        #1;
        check("d0_pop_valid", 32'(c_pop.valid), 1);
        check("d0_pop_data", c_pop.data, 32'h77);
        check("d0_push_ready_lo", 32'(c_push.ready), 0);
        check("d0_full_empty", {30'd0, c_full, c_empty}, 32'h3);
        check("d0_usage", 32'(c_usage), 0);
        c_pop.ready = 1'b1;
        #1;
        check("d0_push_ready_hi", 32'(c_push.ready), 1);
        c_flush = 1'b1;
        #1;
        check("d0_flush_valid", 32'(c_pop.valid), 0);
        check("d0_flush_ready", 32'(c_push.ready), 0);
        c_flush = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
